// File: rtl/mouse_click_filter.sv
// Conditions raw PS/2 mouse data: clamps the cursor to the visible area and
// synchronizes and debounces the left button into a clean level, a click pulse and a click position.
module mouse_click_filter #(
  parameter int XMAX            = 1023,
  parameter int YMAX            = 767,
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int CNT_WIDTH       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic        left_in,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic        left_button,
  output logic        click,
  output logic [11:0] xpos_click,
  output logic [11:0] ypos_click
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [11:0]          XMAX_V   = 12'(XMAX);
  localparam logic [11:0]          YMAX_V   = 12'(YMAX);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 s1, s2;
  logic                 left_s;
  logic [11:0]          xc, yc;
  logic                 click_next;
  logic                 latch_pos;

  assign left_s = s2;
  assign xc     = (xpos_in > XMAX_V) ? XMAX_V : xpos_in;
  assign yc     = (ypos_in > YMAX_V) ? YMAX_V : ypos_in;

  // A release of left_s always wins over a completed count, so a glitch
  // ending exactly on the last debounce cycle is still rejected.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    click_next = 1'b0;
    latch_pos  = 1'b0;
    case (state)
      IDLE: begin
        if (left_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!left_s) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          click_next = 1'b1;
          latch_pos  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!left_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (left_s) begin
          state_next = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      s1          <= 1'b0;
      s2          <= 1'b0;
      xpos_out    <= '0;
      ypos_out    <= '0;
      left_button <= 1'b0;
      click       <= 1'b0;
      xpos_click  <= '0;
      ypos_click  <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      s1          <= left_in;
      s2          <= s1;
      xpos_out    <= xc;
      ypos_out    <= yc;
      left_button <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
      click       <= click_next;
      if (latch_pos) begin
        xpos_click <= xc;
        ypos_click <= yc;
      end
    end
  end

endmodule

// File: tb/tb_mouse_click_filter.sv
// Bench for mouse_click_filter with DEBOUNCE_CYCLES=4: directed scenarios with
// literal expectations plus randomized button/position traffic against a reference model.
module tb_mouse_click_filter;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos_in, ypos_in;
  logic        left_in;
  logic [11:0] xpos_out, ypos_out, xpos_click, ypos_click;
  logic        left_button, click;

  int tests = 0;
  int fails = 0;

  mouse_click_filter #(
    .XMAX(1023), .YMAX(767), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst),
    .xpos_in(xpos_in), .ypos_in(ypos_in), .left_in(left_in),
    .xpos_out(xpos_out), .ypos_out(ypos_out),
    .left_button(left_button), .click(click),
    .xpos_click(xpos_click), .ypos_click(ypos_click)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: the button level flips once left_s (left_in two samples
  // late) has disagreed with it on D+1 consecutive edges.
  bit sh0, sh1, ls, m_lvl, m_click;
  int run;
  int m_x, m_y, m_xc, m_yc;

  always @(posedge clk) begin
    if (rst) begin
      sh0 = 0; sh1 = 0; m_lvl = 0; m_click = 0; run = 0;
      m_x = 0; m_y = 0; m_xc = 0; m_yc = 0;
    end else begin
      ls = sh1;
      sh1 = sh0;
      sh0 = left_in;
      m_click = 0;
      if (ls != m_lvl) begin
        run++;
        if (run == D + 1) begin
          m_lvl = ls;
          run = 0;
          if (ls) begin
            m_click = 1;
            m_xc = clampv(int'(xpos_in), 1023);
            m_yc = clampv(int'(ypos_in), 767);
          end
        end
      end else begin
        run = 0;
      end
      m_x = clampv(int'(xpos_in), 1023);
      m_y = clampv(int'(ypos_in), 767);
    end
  end

  // scoreboard: every cycle, on the falling edge
  always @(negedge clk) begin
    check("xpos_out", int'(xpos_out), m_x);
    check("ypos_out", int'(ypos_out), m_y);
    check("left_button", int'(left_button), int'(m_lvl));
    check("click", int'(click), int'(m_click));
    check("xpos_click", int'(xpos_click), m_xc);
    check("ypos_click", int'(ypos_click), m_yc);
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_click_after(input string name, input int n);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      check({name, "_early"}, int'(click), 0);
    end
    @(negedge clk);
    check(name, int'(click), 1);
  endtask

  int xs[6] = '{1023, 1024, 4095, 0, 500, 1};
  int ys[6] = '{767, 768, 4095, 0, 766, 1};
  int xe[6] = '{1023, 1023, 1023, 0, 500, 1};
  int ye[6] = '{767, 767, 767, 0, 766, 1};

  initial begin
    // 1: reset with button held and out-of-range x
    rst = 1; left_in = 1; xpos_in = 12'd2000; ypos_in = 12'd100;
    cycles(3);
    check("rst_xpos_out", int'(xpos_out), 0);
    check("rst_left_button", int'(left_button), 0);
    check("rst_click", int'(click), 0);
    check("rst_xpos_click", int'(xpos_click), 0);
    rst = 0;
    cycles(1);
    check("post_rst_xpos_out", int'(xpos_out), 1023);
    expect_click_after("post_rst_click", 6);

    // release, then 2: clean press
    left_in = 0;
    cycles(12);
    xpos_in = 12'd500; ypos_in = 12'd360; left_in = 1;
    expect_click_after("press_click", 7);
    check("press_left_button", int'(left_button), 1);
    check("press_xpos_click", int'(xpos_click), 500);
    check("press_ypos_click", int'(ypos_click), 360);
    cycles(1);
    check("press_click_single", int'(click), 0);

    // 4: release bounce, then clean release
    cycles(3);
    left_in = 0; cycles(2); left_in = 1;
    cycles(10);
    check("bounce_left_button", int'(left_button), 1);
    left_in = 0;
    cycles(6);
    check("release_hold", int'(left_button), 1);
    cycles(1);
    check("release_drop", int'(left_button), 0);

    // 3: short glitch while idle
    cycles(3);
    xpos_in = 12'd100; ypos_in = 12'd50;
    left_in = 1; cycles(3); left_in = 0;
    cycles(10);
    check("glitch_left_button", int'(left_button), 0);
    check("glitch_xpos_click", int'(xpos_click), 500);
    check("glitch_ypos_click", int'(ypos_click), 360);

    // 5: clamp boundaries
    foreach (xs[i]) begin
      xpos_in = 12'(xs[i]); ypos_in = 12'(ys[i]);
      cycles(1);
      check("clamp_x", int'(xpos_out), xe[i]);
      check("clamp_y", int'(ypos_out), ye[i]);
    end

    // 6: reset during PRESS_WAIT, button still held afterwards
    left_in = 1;
    cycles(4);
    rst = 1;
    cycles(1); check("mid_rst_click", int'(click), 0);
    cycles(1); check("mid_rst_click2", int'(click), 0);
    rst = 0;
    expect_click_after("mid_rst_after", 7);
    cycles(1);
    check("mid_rst_single", int'(click), 0);

    // randomized traffic: runs of random length around the debounce window
    for (int r = 0; r < 600; r++) begin
      int len;
      len = $urandom_range(1, 9);
      left_in = ~left_in;
      for (int k = 0; k < len; k++) begin
        xpos_in = 12'($urandom_range(0, 4095));
        ypos_in = 12'($urandom_range(0, 4095));
        rst = ($urandom_range(0, 299) == 0);
        cycles(1);
      end
    end
    rst = 0;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
